// File: rtl/key_event_mapper.sv
// key_event_mapper
//   Maps NUM_KEYS PS/2 scan codes, taken from the KeyboardDecoder key level
//   vector, to per-channel single-cycle press pulses. With the
//   KEY_EVENT_AUTO_REPEAT_EN macro defined, each channel also produces
//   typematic repeat pulses: the first repeat comes REPEAT_DELAY cycles after
//   the press pulse, and later repeats follow every REPEAT_PERIOD cycles.
//   Without the macro, each press gives exactly one pulse.
//
// Ports
//   clk        system clock
//   rst        asynchronous, active-high reset
//   enable     low forces every channel idle and suppresses all pulses
//   key_down   512-bit key level vector from KeyboardDecoder
//   key_pulse  one-cycle press/repeat pulse per channel
//   key_held   registered key level per channel (enable-qualified)
//   any_pulse  OR of key_pulse, aligned with it
//   first_key  lowest channel index whose key_pulse is high, 0 when none
module key_event_mapper #(
  parameter int                    NUM_KEYS      = 7,
  parameter logic [9*NUM_KEYS-1:0] KEY_CODES     = {NUM_KEYS{9'h000}},
  parameter int                    REPEAT_DELAY  = 25_000_000,
  parameter int                    REPEAT_PERIOD = 10_000_000,
  parameter int                    IDX_W         = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [511:0]        key_down,
  output logic [NUM_KEYS-1:0] key_pulse,
  output logic [NUM_KEYS-1:0] key_held,
  output logic                any_pulse,
  output logic [IDX_W-1:0]    first_key
);

`ifdef KEY_EVENT_AUTO_REPEAT_EN
  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } state_e;

  logic [CNT_W-1:0] cnt_r [NUM_KEYS];
`else
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HELD = 1'b1
  } state_e;

  // Timing parameters have no effect in the single-pulse build.
  logic [31:0] unused_cfg_s;
  assign unused_cfg_s = REPEAT_DELAY ^ REPEAT_PERIOD;
`endif

  state_e              state_r [NUM_KEYS];
  logic [NUM_KEYS-1:0] sample_s;
  logic [NUM_KEYS-1:0] fire_s;
  logic [IDX_W-1:0]    first_nxt_s;
  logic [NUM_KEYS-1:0] key_pulse_r;
  logic [NUM_KEYS-1:0] key_held_r;
  logic                any_pulse_r;
  logic [IDX_W-1:0]    first_key_r;

  // Only the mapped scan-code bits of key_down are looked at.
  logic unused_key_down_s;
  assign unused_key_down_s = ^key_down;

  // Pick each channel's key level out of key_down, gated by enable.
  always_comb begin
    sample_s = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      sample_s[i] = enable & key_down[KEY_CODES[9*i +: 9]];
    end
  end

  // Decide per channel whether a press or repeat event fires on this edge.
  always_comb begin
    fire_s = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      case (state_r[i])
        ST_IDLE:   fire_s[i] = sample_s[i] & ~key_held_r[i];
`ifdef KEY_EVENT_AUTO_REPEAT_EN
        ST_DELAY:  fire_s[i] = sample_s[i] & (cnt_r[i] == DELAY_LAST);
        ST_REPEAT: fire_s[i] = sample_s[i] & (cnt_r[i] == PERIOD_LAST);
`else
        ST_HELD:   fire_s[i] = 1'b0;
`endif
        default:   fire_s[i] = 1'b0;
      endcase
    end
  end

  // Lowest firing channel index; scanning downward lets the lowest win.
  always_comb begin
    first_nxt_s = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (fire_s[i]) begin
        first_nxt_s = IDX_W'(i);
      end else begin
        first_nxt_s = first_nxt_s;
      end
    end
  end

  // Channel FSMs, repeat counters and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_pulse_r <= '0;
      key_held_r  <= '0;
      any_pulse_r <= 1'b0;
      first_key_r <= '0;
      for (int i = 0; i < NUM_KEYS; i++) begin
        state_r[i] <= ST_IDLE;
`ifdef KEY_EVENT_AUTO_REPEAT_EN
        cnt_r[i]   <= '0;
`endif
      end
    end else begin
      key_pulse_r <= fire_s;
      key_held_r  <= sample_s;
      any_pulse_r <= |fire_s;
      first_key_r <= first_nxt_s;
      for (int i = 0; i < NUM_KEYS; i++) begin
`ifdef KEY_EVENT_AUTO_REPEAT_EN
        case (state_r[i])
          ST_IDLE: begin
            cnt_r[i] <= '0;
            if (sample_s[i] && !key_held_r[i]) begin
              state_r[i] <= ST_DELAY;
            end else begin
              state_r[i] <= ST_IDLE;
            end
          end
          ST_DELAY: begin
            if (!sample_s[i]) begin
              state_r[i] <= ST_IDLE;
              cnt_r[i]   <= '0;
            end else if (cnt_r[i] == DELAY_LAST) begin
              state_r[i] <= ST_REPEAT;
              cnt_r[i]   <= '0;
            end else begin
              cnt_r[i]   <= cnt_r[i] + CNT_W'(1);
            end
          end
          ST_REPEAT: begin
            if (!sample_s[i]) begin
              state_r[i] <= ST_IDLE;
              cnt_r[i]   <= '0;
            end else if (cnt_r[i] == PERIOD_LAST) begin
              cnt_r[i]   <= '0;
            end else begin
              cnt_r[i]   <= cnt_r[i] + CNT_W'(1);
            end
          end
          default: begin
            state_r[i] <= ST_IDLE;
            cnt_r[i]   <= '0;
          end
        endcase
`else
        case (state_r[i])
          ST_IDLE: begin
            if (sample_s[i] && !key_held_r[i]) begin
              state_r[i] <= ST_HELD;
            end else begin
              state_r[i] <= ST_IDLE;
            end
          end
          ST_HELD: begin
            if (!sample_s[i]) begin
              state_r[i] <= ST_IDLE;
            end else begin
              state_r[i] <= ST_HELD;
            end
          end
          default: state_r[i] <= ST_IDLE;
        endcase
`endif
      end
    end
  end

  assign key_pulse = key_pulse_r;
  assign key_held  = key_held_r;
  assign any_pulse = any_pulse_r;
  assign first_key = first_key_r;

endmodule

// File: tb/tb_key_event_mapper.sv
// Self-checking bench for key_event_mapper: directed test-plan sequences
// followed by randomized key/enable/reset stimulus, all checked each cycle
// against a press-age reference model.
module tb_key_event_mapper;

  localparam int NK = 4;
  localparam int RD = 8;
  localparam int RP = 4;
  // Channel 0 right, 1 left, 2 down, 3 up.
  localparam logic [9*NK-1:0] CODES = {9'h175, 9'h172, 9'h16B, 9'h174};
`ifdef KEY_EVENT_AUTO_REPEAT_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          enable = 1'b1;
  logic [511:0]  key_down = '0;
  logic [NK-1:0] key_pulse;
  logic [NK-1:0] key_held;
  logic          any_pulse;
  logic [4:0]    first_key;

  key_event_mapper #(
    .NUM_KEYS     (NK),
    .KEY_CODES    (CODES),
    .REPEAT_DELAY (RD),
    .REPEAT_PERIOD(RP),
    .IDX_W        (5)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .key_down (key_down),
    .key_pulse(key_pulse),
    .key_held (key_held),
    .any_pulse(any_pulse),
    .first_key(first_key)
  );

  always #5 clk = ~clk;

  // Reference model: age[i] = edges since channel i was pressed.
  int            age [NK];
  logic [NK-1:0] exp_pulse = '0;
  logic [NK-1:0] exp_held  = '0;
  logic          exp_any   = 1'b0;
  logic [4:0]    exp_first = '0;

  function automatic logic [NK-1:0] sample_f(input logic en, input logic [511:0] kd);
    logic [NK-1:0] r;
    logic [8:0]    code;
    for (int i = 0; i < NK; i++) begin
      code = CODES[9*i +: 9];
      r[i] = en & kd[code];
    end
    return r;
  endfunction

  function automatic logic [NK-1:0] pulse_f(input logic [NK-1:0] s, input logic [NK-1:0] prev);
    logic [NK-1:0] p;
    int an;
    for (int i = 0; i < NK; i++) begin
      an = prev[i] ? age[i] + 1 : 0;
      p[i] = s[i] && (an == 0 || (AUTO && an >= RD && ((an - RD) % RP) == 0));
    end
    return p;
  endfunction

  function automatic logic [4:0] lowest_f(input logic [NK-1:0] p);
    for (int i = 0; i < NK; i++) begin
      if (p[i]) return 5'(i);
    end
    return 5'd0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NK; i++) age[i] <= 0;
      exp_pulse <= '0;
      exp_held  <= '0;
      exp_any   <= 1'b0;
      exp_first <= '0;
    end else begin
      for (int i = 0; i < NK; i++) age[i] <= exp_held[i] ? age[i] + 1 : 0;
      exp_held  <= sample_f(enable, key_down);
      exp_pulse <= pulse_f(sample_f(enable, key_down), exp_held);
      exp_any   <= |pulse_f(sample_f(enable, key_down), exp_held);
      exp_first <= lowest_f(pulse_f(sample_f(enable, key_down), exp_held));
    end
  end

  int n_cmp = 0;
  int n_err = 0;
  int pulses;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Advance to the next falling edge and compare every output to the model.
  task automatic tick();
    @(negedge clk);
    chk("key_pulse", 32'(key_pulse), 32'(exp_pulse));
    chk("key_held",  32'(key_held),  32'(exp_held));
    chk("any_pulse", 32'(any_pulse), 32'(exp_any));
    chk("first_key", 32'(first_key), 32'(exp_first));
  endtask

  initial begin
    // 1. Reset with up held.
    #2;
    rst = 1'b1;
    key_down[9'h175] = 1'b1;
    repeat (3) begin
      tick();
      chk("reset_pulse", 32'(key_pulse), 32'h0);
      chk("reset_held",  32'(key_held),  32'h0);
    end
    rst = 1'b0;
    tick();
    chk("post_reset_pulse", 32'(key_pulse), 32'h8);
    chk("post_reset_any",   32'(any_pulse), 32'h1);
    chk("post_reset_first", 32'(first_key), 32'h3);
    pulses = int'(key_pulse[3]);

    // 2. Hold for 30 cycles in total.
    repeat (29) begin
      tick();
      pulses += int'(key_pulse[3]);
    end
    chk("hold30_pulse_count", 32'(pulses), AUTO ? 32'd7 : 32'd1);

    // 3. Release, re-press, early release, re-press.
    key_down[9'h175] = 1'b0;
    tick();
    key_down[9'h175] = 1'b1;
    tick();
    chk("press_pulse", 32'(key_pulse), 32'h8);
    repeat (4) tick();
    key_down[9'h175] = 1'b0;
    repeat (2) tick();
    key_down[9'h175] = 1'b1;
    tick();
    chk("repress_pulse", 32'(key_pulse), 32'h8);
    pulses = 0;
    repeat (8) begin
      tick();
      pulses += int'(key_pulse[3]);
    end
    chk("repress_repeat_count", 32'(pulses), AUTO ? 32'd1 : 32'd0);

    // 4. Simultaneous left + down.
    key_down = '0;
    repeat (2) tick();
    key_down[9'h16B] = 1'b1;
    key_down[9'h172] = 1'b1;
    tick();
    chk("simul_pulse", 32'(key_pulse), 32'h6);
    chk("simul_first", 32'(first_key), 32'h1);
    chk("simul_any",   32'(any_pulse), 32'h1);
    tick();
    chk("simul_width", 32'(key_pulse), 32'h0);

    // 5. enable gating with up held.
    key_down = '0;
    key_down[9'h175] = 1'b1;
    repeat (3) tick();
    enable = 1'b0;
    tick();
    chk("disabled_pulse", 32'(key_pulse), 32'h0);
    chk("disabled_held",  32'(key_held),  32'h0);
    tick();
    enable = 1'b1;
    tick();
    chk("reenable_pulse", 32'(key_pulse), 32'h8);

    // Randomized phase.
    key_down = '0;
    for (int n = 0; n < 4000; n++) begin
      for (int i = 0; i < NK; i++) begin
        if ($urandom_range(9, 0) == 0) begin
          logic [8:0] c;
          c = CODES[9*i +: 9];
          key_down[c] = ~key_down[c];
        end
      end
      if ($urandom_range(3, 0) == 0) key_down[$urandom_range(511, 0)] = 1'($urandom);
      if ($urandom_range(39, 0) == 0) enable = ~enable;
      rst = ($urandom_range(299, 0) == 0);
      tick();
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
